// File: rtl/ansi_decoder.sv
// Receive-side byte parser: splits a host byte stream into printable characters and decoded
// C0 / ANSI CSI cursor, erase and attribute commands. All outputs are registered.
module ansi_decoder #(
   parameter int unsigned COLS = 80,
   parameter int unsigned ROWS = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i_byte,
   input  logic       i_byte_v,
   output logic [7:0] o_char,
   output logic       o_char_v,
   output logic [3:0] o_cmd,
   output logic       o_cmd_v,
   output logic [7:0] o_p0,
   output logic [7:0] o_p1
);

   localparam logic [3:0] CmdCr  = 4'd1;
   localparam logic [3:0] CmdLf  = 4'd2;
   localparam logic [3:0] CmdBs  = 4'd3;
   localparam logic [3:0] CmdHt  = 4'd4;
   localparam logic [3:0] CmdBel = 4'd5;
   localparam logic [3:0] CmdCuu = 4'd6;
   localparam logic [3:0] CmdCud = 4'd7;
   localparam logic [3:0] CmdCuf = 4'd8;
   localparam logic [3:0] CmdCub = 4'd9;
   localparam logic [3:0] CmdCup = 4'd10;
   localparam logic [3:0] CmdEd  = 4'd11;
   localparam logic [3:0] CmdEl  = 4'd12;
   localparam logic [3:0] CmdSgr = 4'd13;

   localparam logic [7:0] RowMax = 8'(ROWS - 1);
   localparam logic [7:0] ColMax = 8'(COLS - 1);

   typedef enum logic [1:0] {StGround, StEsc, StCsi} state_e;

   state_e     state_q, state_d;
   logic [7:0] p0_q, p0_d;
   logic [7:0] p1_q, p1_d;
   logic [1:0] cnt_q, cnt_d;
   logic       ign_q, ign_d;
   logic [7:0] char_q, char_d;
   logic       char_v_q, char_v_d;
   logic [3:0] cmd_q, cmd_d;
   logic       cmd_v_q, cmd_v_d;
   logic [7:0] op0_q, op0_d;
   logic [7:0] op1_q, op1_d;

   // Format-effector controls that execute in any state; 0 means "not one of them".
   function automatic logic [3:0] exec_code(input logic [7:0] b);
      logic [3:0] c;
      c = 4'd0;
      case (b)
         8'h0D:   c = CmdCr;
         8'h0A:   c = CmdLf;
         8'h08:   c = CmdBs;
         8'h09:   c = CmdHt;
         8'h07:   c = CmdBel;
         default: c = 4'd0;
      endcase
      return c;
   endfunction

   function automatic logic [7:0] acc_digit(input logic [7:0] acc, input logic [7:0] b);
      logic [11:0] t;
      t = {4'd0, acc} * 12'd10 + {8'd0, b[3:0]};
      return (t > 12'd255) ? 8'd255 : t[7:0];
   endfunction

   // 1-based parameter (0 or missing means 1) to clamped 0-based coordinate.
   function automatic logic [7:0] cup_coord(input logic [7:0] p, input logic [7:0] lim);
      logic [7:0] z;
      z = (p == 8'd0) ? 8'd0 : p - 8'd1;
      return (z > lim) ? lim : z;
   endfunction

   logic [3:0] exec;
   assign exec = exec_code(i_byte);

   always_comb begin
      state_d  = state_q;
      p0_d     = p0_q;
      p1_d     = p1_q;
      cnt_d    = cnt_q;
      ign_d    = ign_q;
      char_d   = char_q;
      char_v_d = 1'b0;
      cmd_d    = cmd_q;
      cmd_v_d  = 1'b0;
      op0_d    = op0_q;
      op1_d    = op1_q;

      if (i_byte_v) begin
         if (state_q == StGround) begin
            if (i_byte >= 8'h20 && i_byte <= 8'h7E) begin
               char_d   = i_byte;
               char_v_d = 1'b1;
            end else if (exec != 4'd0) begin
               cmd_d   = exec;
               cmd_v_d = 1'b1;
               op0_d   = 8'd0;
               op1_d   = 8'd0;
            end else if (i_byte == 8'h1B) begin
               state_d = StEsc;
            end
         end else if (i_byte[7]) begin
            state_d = StGround;
         end else if (i_byte == 8'h1B) begin
            state_d = StEsc;
         end else if (i_byte == 8'h18 || i_byte == 8'h1A) begin
            state_d = StGround;
         end else if (exec != 4'd0) begin
            // Sequence state and params are left untouched.
            cmd_d   = exec;
            cmd_v_d = 1'b1;
            op0_d   = 8'd0;
            op1_d   = 8'd0;
         end else if (i_byte < 8'h20 || i_byte == 8'h7F) begin
            state_d = state_q;
         end else if (state_q == StEsc) begin
            if (i_byte == 8'h5B) begin
               state_d = StCsi;
               p0_d    = 8'd0;
               p1_d    = 8'd0;
               cnt_d   = 2'd0;
               ign_d   = 1'b0;
            end else begin
               state_d = StGround;
            end
         end else if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
            if (cnt_q == 2'd0) begin
               p0_d = acc_digit(p0_q, i_byte);
            end else if (cnt_q == 2'd1) begin
               p1_d = acc_digit(p1_q, i_byte);
            end
         end else if (i_byte == 8'h3B) begin
            if (cnt_q != 2'd3) begin
               cnt_d = cnt_q + 2'd1;
            end
         end else if (i_byte >= 8'h40) begin
            state_d = StGround;
            if (!ign_q) begin
               cmd_v_d = 1'b1;
               op0_d   = 8'd0;
               op1_d   = 8'd0;
               case (i_byte)
                  8'h41: cmd_d = CmdCuu;
                  8'h42: cmd_d = CmdCud;
                  8'h43: cmd_d = CmdCuf;
                  8'h44: cmd_d = CmdCub;
                  8'h48, 8'h66: begin
                     cmd_d = CmdCup;
                     op0_d = cup_coord(p0_q, RowMax);
                     op1_d = cup_coord(p1_q, ColMax);
                  end
                  8'h4A: begin
                     cmd_d = CmdEd;
                     op0_d = p0_q;
                  end
                  8'h4B: begin
                     cmd_d = CmdEl;
                     op0_d = p0_q;
                  end
                  8'h6D: begin
                     cmd_d = CmdSgr;
                     op0_d = p0_q;
                     op1_d = p1_q;
                  end
                  default: begin
                     cmd_d   = cmd_q;
                     cmd_v_d = 1'b0;
                     op0_d   = op0_q;
                     op1_d   = op1_q;
                  end
               endcase
               if (i_byte >= 8'h41 && i_byte <= 8'h44) begin
                  op0_d = (p0_q == 8'd0) ? 8'd1 : p0_q;
               end
            end
         end else begin
            // Intermediates, private markers and ':' poison the sequence.
            ign_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StGround;
         p0_q     <= 8'd0;
         p1_q     <= 8'd0;
         cnt_q    <= 2'd0;
         ign_q    <= 1'b0;
         char_q   <= 8'd0;
         char_v_q <= 1'b0;
         cmd_q    <= 4'd0;
         cmd_v_q  <= 1'b0;
         op0_q    <= 8'd0;
         op1_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         p0_q     <= p0_d;
         p1_q     <= p1_d;
         cnt_q    <= cnt_d;
         ign_q    <= ign_d;
         char_q   <= char_d;
         char_v_q <= char_v_d;
         cmd_q    <= cmd_d;
         cmd_v_q  <= cmd_v_d;
         op0_q    <= op0_d;
         op1_q    <= op1_d;
      end
   end

   assign o_char   = char_q;
   assign o_char_v = char_v_q;
   assign o_cmd    = cmd_q;
   assign o_cmd_v  = cmd_v_q;
   assign o_p0     = op0_q;
   assign o_p1     = op1_q;

endmodule

// File: tb/tb_ansi_decoder.sv
// Directed bench for ansi_decoder: bytes are driven on consecutive cycles and each output
// pulse is checked one cycle after the byte that completes it.
module tb_ansi_decoder;

   logic       clk;
   logic       rst_n;
   logic [7:0] i_byte;
   logic       i_byte_v;
   logic [7:0] o_char;
   logic       o_char_v;
   logic [3:0] o_cmd;
   logic       o_cmd_v;
   logic [7:0] o_p0;
   logic [7:0] o_p1;

   int nvec = 0;
   int nerr = 0;

   ansi_decoder #(.COLS(80), .ROWS(24)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_byte   (i_byte),
      .i_byte_v (i_byte_v),
      .o_char   (o_char),
      .o_char_v (o_char_v),
      .o_cmd    (o_cmd),
      .o_cmd_v  (o_cmd_v),
      .o_p0     (o_p0),
      .o_p1     (o_p1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; returns at the next negedge with the byte's result on the outputs.
   task automatic send(input logic [7:0] b);
      i_byte   = b;
      i_byte_v = 1'b1;
      @(negedge clk);
      i_byte_v = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_none(input string tag);
      chk({tag, ".char_v"}, 32'(o_char_v), 32'd0);
      chk({tag, ".cmd_v"}, 32'(o_cmd_v), 32'd0);
   endtask

   task automatic chk_char(input string tag, input logic [7:0] c);
      chk({tag, ".char_v"}, 32'(o_char_v), 32'd1);
      chk({tag, ".cmd_v"}, 32'(o_cmd_v), 32'd0);
      chk({tag, ".char"}, 32'(o_char), 32'(c));
   endtask

   task automatic chk_cmd(input string tag, input logic [3:0] c, input logic [7:0] p0,
                          input logic [7:0] p1);
      chk({tag, ".cmd_v"}, 32'(o_cmd_v), 32'd1);
      chk({tag, ".char_v"}, 32'(o_char_v), 32'd0);
      chk({tag, ".cmd"}, 32'(o_cmd), 32'(c));
      chk({tag, ".p0"}, 32'(o_p0), 32'(p0));
      chk({tag, ".p1"}, 32'(o_p1), 32'(p1));
   endtask

   task automatic chk_zero(input string tag);
      chk_none(tag);
      chk({tag, ".char"}, 32'(o_char), 32'd0);
      chk({tag, ".cmd"}, 32'(o_cmd), 32'd0);
      chk({tag, ".p0"}, 32'(o_p0), 32'd0);
      chk({tag, ".p1"}, 32'(o_p1), 32'd0);
   endtask

   // ESC followed by the given bytes, none of which may produce output.
   task automatic quiet(input string tag, input string s);
      send(8'h1B);
      chk_none({tag, ".esc"});
      for (int i = 0; i < s.len(); i++) begin
         send(s[i]);
         chk_none(tag);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      i_byte   = 8'd0;
      i_byte_v = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      send(8'h41);  chk_char("A", 8'h41);
      send(8'h7E);  chk_char("tilde", 8'h7E);
      send(8'h7F);  chk_none("del");
      send(8'h05);  chk_none("enq");
      send(8'h09);  chk_cmd("ht", 4'd4, 8'd0, 8'd0);
      send(8'h07);  chk_cmd("bel", 4'd5, 8'd0, 8'd0);
      send(8'h0A);  chk_cmd("lf", 4'd2, 8'd0, 8'd0);
      send(8'h08);  chk_cmd("bs", 4'd3, 8'd0, 8'd0);
      send(8'hC3);  chk_none("hi_byte");

      quiet("cup1", "[12;40");    send("H"); chk_cmd("cup1", 4'd10, 8'd11, 8'd39);
      quiet("cup2", "[99;200");   send("H"); chk_cmd("cup2", 4'd10, 8'd23, 8'd79);
      quiet("cup3", "[");         send("f"); chk_cmd("cup3", 4'd10, 8'd0, 8'd0);
      quiet("cuu", "[");          send("A"); chk_cmd("cuu", 4'd6, 8'd1, 8'd0);
      quiet("cuf", "[0");         send("C"); chk_cmd("cuf", 4'd8, 8'd1, 8'd0);
      quiet("cub", "[999");       send("D"); chk_cmd("cub", 4'd9, 8'd255, 8'd0);
      quiet("cud", "[7");         send("B"); chk_cmd("cud", 4'd7, 8'd7, 8'd0);
      quiet("ed", "[2");          send("J"); chk_cmd("ed", 4'd11, 8'd2, 8'd0);
      quiet("el", "[");           send("K"); chk_cmd("el", 4'd12, 8'd0, 8'd0);
      quiet("sgr", "[1;31;4");    send("m"); chk_cmd("sgr", 4'd13, 8'd1, 8'd31);

      quiet("priv", "[?25h");
      chk("hold.cmd", 32'(o_cmd), 32'd13);
      chk("hold.p0", 32'(o_p0), 32'd1);
      chk("hold.p1", 32'(o_p1), 32'd31);
      quiet("unk", "[5q");
      send("x");  chk_char("x", 8'h78);

      quiet("mid_cr", "[10");
      send(8'h0D); chk_cmd("mid_cr.cr", 4'd1, 8'd0, 8'd0);
      send(";");   chk_none("mid_cr.semi");
      send("5");   chk_none("mid_cr.5");
      send("H");   chk_cmd("mid_cr.cup", 4'd10, 8'd9, 8'd4);

      quiet("can", "[3");
      send(8'h18); chk_none("can.can");
      send("B");   chk_char("can.B", 8'h42);

      quiet("escesc", "");
      quiet("escesc2", "[2");
      send("A");   chk_cmd("escesc", 4'd6, 8'd2, 8'd0);

      quiet("rst_mid", "[4");
      rst_n = 1'b0;
      #1;
      chk_zero("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send("A");   chk_char("rst_mid.A", 8'h41);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
